// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and load-use stall control for
// the EX stage. A 3-entry shadow pipeline (E, M, W) mirrors the destination
// and write/load flags of the instructions downstream of ID.
// Optional feature macro: FWD_POSTWB_EN (W entry also forwards, select 11).

// Per-operand priority encoder: picks the most recent producer.
module fwd_sel_lane (
  input  logic       use_i,
  input  logic [2:0] hit_i,   // [0]=E, [1]=M, [2]=W produces the operand
  output logic [1:0] sel_o
);
  // most-recent producer wins; an unused operand always reads the regfile
  always_comb begin
    sel_o = 2'b00;
    if (use_i) begin
      if (hit_i[0])      sel_o = 2'b01;
      else if (hit_i[1]) sel_o = 2'b10;
      else if (hit_i[2]) sel_o = 2'b11;
    end
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  i_rs,
  input  logic [REG_ADDR_WIDTH-1:0]  i_rt,
  input  logic                       i_uses_rs,
  input  logic                       i_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0]  i_dst,
  input  logic                       i_regwrite,
  input  logic                       i_memread,
  input  logic                       i_freeze,
  input  logic                       i_flush,
  output logic [1:0]                 o_sel_a,
  output logic [1:0]                 o_sel_b,
  output logic                       o_stall,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_count
);
  localparam int NUM_OPS = 2;   // operand A (rs), operand B (rt)
  localparam int STAGES  = 3;   // 0=E, 1=M, 2=W

  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] dst;
    logic                      rw;
    logic                      mr;
  } ent_t;

  ent_t [STAGES-1:0]                       ent_q, ent_d;
  logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0]  src;
  logic [NUM_OPS-1:0]                      uses;
  logic [NUM_OPS-1:0][STAGES-1:0]          hit;
  logic [NUM_OPS-1:0]                      ld_hit;
  logic [NUM_OPS-1:0][1:0]                 lane_sel, sel_d, sel_q;
  logic [STALL_CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic                                    stall, enter;
  logic                                    w_unused;

  assign src  = {i_rt, i_rs};
  assign uses = {i_uses_rt, i_uses_rs};

  // producer match per operand per stage; r0 never matches
  for (genvar o = 0; o < NUM_OPS; o++) begin : g_op
    for (genvar s = 0; s < STAGES; s++) begin : g_st
      if (s == STAGES-1) begin : g_w
`ifdef FWD_POSTWB_EN
        assign hit[o][s] = ent_q[s].vld & ent_q[s].rw &
                           (ent_q[s].dst == src[o]) & (src[o] != '0);
`else
        // write-before-read regfile already holds the W result
        assign hit[o][s] = 1'b0;
`endif
      end else begin : g_em
        assign hit[o][s] = ent_q[s].vld & ent_q[s].rw &
                           (ent_q[s].dst == src[o]) & (src[o] != '0);
      end
    end
    assign ld_hit[o] = uses[o] & (src[o] == ent_q[0].dst);

    fwd_sel_lane u_lane (
      .use_i (uses[o]),
      .hit_i (hit[o]),
      .sel_o (lane_sel[o])
    );
  end

  // load in E feeding the ID instruction needs one bubble; flush overrides
  assign stall = i_valid & ~i_flush & ent_q[0].vld & ent_q[0].mr & ent_q[0].rw &
                 (ent_q[0].dst != '0) & (|ld_hit);
  assign enter = i_valid & ~stall & ~i_flush;

  // next-state for shadow pipe, selects and saturating stall counter
  always_comb begin
    ent_d    = {ent_q[1], ent_q[0], ent_t'('0)};
    sel_d    = '0;
    cnt_d    = cnt_q;
    if (enter) begin
      ent_d[0] = '{vld: 1'b1, dst: i_dst, rw: i_regwrite, mr: i_memread};
      sel_d    = lane_sel;
    end
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  // state advances on every non-frozen edge
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ent_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!i_freeze) begin
      ent_q <= ent_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // load flags of M/W and, in some builds, all of W are never consumed
  assign w_unused = ^{ent_q[2], ent_q[1].mr};

  assign o_sel_a       = sel_q[0];
  assign o_sel_b       = sel_q[1];
  assign o_stall       = stall;
  assign o_stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a driver issues directed and random
// ID instructions, predicts outputs from a history of what entered EX, and
// queues expectations; a monitor pops and compares after each rising edge.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 3;   // narrow counter so saturation is reachable

  logic          i_clock = 1'b0, i_reset_n = 1'b0;
  logic          i_valid = 1'b0, i_uses_rs = 1'b0, i_uses_rt = 1'b0;
  logic [AW-1:0] i_rs = '0, i_rt = '0, i_dst = '0;
  logic          i_regwrite = 1'b0, i_memread = 1'b0, i_freeze = 1'b0, i_flush = 1'b0;
  logic [1:0]    o_sel_a, o_sel_b;
  logic          o_stall;
  logic [CW-1:0] o_stall_count;

  fwd_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(CW)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid),
    .i_rs(i_rs), .i_rt(i_rt), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
    .i_dst(i_dst), .i_regwrite(i_regwrite), .i_memread(i_memread),
    .i_freeze(i_freeze), .i_flush(i_flush),
    .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_stall(o_stall),
    .o_stall_count(o_stall_count));

  always #5 i_clock = ~i_clock;

  typedef struct { bit v; int dst; bit rw; bit mr; } ins_t;
  typedef struct { int a; int b; int cnt; } exp_t;

  ins_t hist[3];          // instructions that entered EX, most recent first
  exp_t q[$];
  int   m_a, m_b, m_cnt;
  int   total = 0, bad = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd(int r);
    if (r == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (hist[i].v && hist[i].rw && hist[i].dst == r) begin
`ifndef FWD_POSTWB_EN
        if (i == 2) return 0;
`endif
        return i + 1;
      end
    return 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
    m_a = 0; m_b = 0; m_cnt = 0;
  endfunction

  // monitor: compare registered outputs after every edge that has an expectation
  always @(posedge i_clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sel_a", int'(o_sel_a), e.a);
      chk("sel_b", int'(o_sel_b), e.b);
      chk("stall_count", int'(o_stall_count), e.cnt);
    end
  end

  task automatic step(bit v, int rs, int rt, bit urs, bit urt, int dst,
                      bit rw, bit mr, bit frz, bit fl);
    bit es, ld;
    ins_t n;
    @(negedge i_clock);
    i_valid = v; i_rs = AW'(rs); i_rt = AW'(rt); i_uses_rs = urs; i_uses_rt = urt;
    i_dst = AW'(dst); i_regwrite = rw; i_memread = mr; i_freeze = frz; i_flush = fl;
    #1;
    ld = hist[0].v && hist[0].mr && hist[0].rw && hist[0].dst != 0;
    es = v && !fl && ld && ((urs && rs == hist[0].dst) || (urt && rt == hist[0].dst));
    chk("stall", int'(o_stall), int'(es));
    if (!frz) begin
      if (v && !es && !fl) begin
        m_a = urs ? fwd(rs) : 0;
        m_b = urt ? fwd(rt) : 0;
        n = '{1, dst, rw, mr};
      end else begin
        m_a = 0; m_b = 0;
        n = '{0, 0, 0, 0};
      end
      if (es && m_cnt < (1 << CW) - 1) m_cnt++;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = n;
    end
    q.push_back('{m_a, m_b, m_cnt});
  endtask

  task automatic op(int rs, int rt, int dst, bit mr = 0);
    step(1, rs, rt, 1, 1, dst, 1, mr, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset_n = 1'b0;
    #1;
    chk("rst_sel_a", int'(o_sel_a), 0);
    chk("rst_sel_b", int'(o_sel_b), 0);
    chk("rst_stall", int'(o_stall), 0);
    chk("rst_count", int'(o_stall_count), 0);
    model_clear();
    @(posedge i_clock);
    #2 i_reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    chk("por_sel_a", int'(o_sel_a), 0);
    chk("por_stall", int'(o_stall), 0);
    chk("por_count", int'(o_stall_count), 0);
    @(posedge i_clock);
    #2 i_reset_n = 1'b1;

    // EX->EX forward
    op(1, 2, 3);  op(3, 5, 4);  op(20, 21, 22);
    // MEM forward, then post-WB distance
    op(1, 2, 3);  op(10, 11, 12); op(6, 3, 13);
    op(1, 2, 3);  op(10, 11, 12); op(14, 15, 16); op(6, 3, 17);
    // load-use: stall once, then select 10 from M
    op(1, 0, 7, 1); op(7, 7, 8); op(7, 7, 8);
    // priority: two writers of r9
    op(1, 2, 9); op(4, 5, 9); op(9, 9, 10);
    // r0 writer then r0 reader (also as a load)
    op(1, 2, 0, 1); op(0, 0, 11);
    // flush wins over stall
    op(1, 0, 7, 1); step(1, 7, 7, 1, 1, 8, 1, 0, 0, 1); op(7, 7, 8);
    // freeze for 3 cycles mid-sequence, with a pending load-use
    op(1, 0, 6, 1);
    repeat (3) step(1, 6, 2, 1, 1, 8, 1, 0, 1, 0);
    op(6, 2, 8); op(6, 2, 8);
    // reset mid-sequence
    op(1, 0, 5, 1);
    do_reset();
    op(5, 5, 6);

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      if (n == 800) do_reset();
      step($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8);
    end

    @(negedge i_clock);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
